// File: rtl/feistel_pkg.sv
// rtl/feistel_pkg.sv - shared state encoding, round function and key schedule for the Feistel engine
package feistel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int F_ROT = 5;
  localparam int MAX_W = 128;

  // Operands are zero-extended to MAX_W so one function serves every half width h.
  function automatic logic [MAX_W-1:0] feistel_f(input logic [MAX_W-1:0] r,
                                                 input logic [MAX_W-1:0] k,
                                                 input int h);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] t;
    logic [MAX_W-1:0] rot;
    int s;
    mask = (h >= MAX_W) ? '1 : ((MAX_W'(1) << h) - MAX_W'(1));
    s    = F_ROT % h;
    t    = (r ^ k) & mask;
    rot  = ((t << s) | (t >> (h - s))) & mask;
    return (rot + (k & mask)) & mask;
  endfunction

  function automatic logic [MAX_W-1:0] subkey(input logic [MAX_W-1:0] key,
                                              input int idx,
                                              input int key_w = 56,
                                              input int h     = 32,
                                              input int rot   = 4);
    logic [MAX_W-1:0] kmask;
    logic [MAX_W-1:0] hmask;
    logic [MAX_W-1:0] kk;
    int s;
    kmask = (key_w >= MAX_W) ? '1 : ((MAX_W'(1) << key_w) - MAX_W'(1));
    hmask = (h >= MAX_W) ? '1 : ((MAX_W'(1) << h) - MAX_W'(1));
    s     = (idx * rot) % key_w;
    kk    = key & kmask;
    return (((kk << s) | (kk >> (key_w - s))) & kmask) & hmask;
  endfunction

endpackage

// File: rtl/feistel_round.sv
// rtl/feistel_round.sv - one combinational Feistel round: L' = R, R' = L ^ F(R, k)
module feistel_round
  import feistel_pkg::*;
#(
  parameter int H = 32
) (
  input  logic [H-1:0] l,
  input  logic [H-1:0] r,
  input  logic [H-1:0] k,
  output logic [H-1:0] l_n,
  output logic [H-1:0] r_n
);

  assign l_n = r;
  assign r_n = l ^ H'(feistel_f(MAX_W'(r), MAX_W'(k), H));

endmodule

// File: rtl/feistel_iter_core.sv
// rtl/feistel_iter_core.sv - iterative handshaked Feistel engine, UNROLL rounds per clock
// FEISTEL_KEY_CLEAR_EN: wipe key/data registers on the output handshake and blank out_block while idle.
module feistel_iter_core
  import feistel_pkg::*;
#(
  parameter int BLOCK_W = 64,
  parameter int KEY_W   = 56,
  parameter int ROUNDS  = 16,
  parameter int UNROLL  = 1,
  parameter int KEY_ROT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_decrypt,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy
);

  localparam int H    = BLOCK_W / 2;
  localparam int RC_W = $clog2(ROUNDS + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  if ((ROUNDS % UNROLL) != 0 || (BLOCK_W % 2) != 0 || BLOCK_W < 8 ||
      KEY_W < H || ROUNDS < 1 || KEY_W > MAX_W) begin : g_bad_params
    $error("feistel_iter_core: illegal parameter combination");
  end

  logic [1:0]         state;
  logic [H-1:0]       l_q;
  logic [H-1:0]       r_q;
  logic [KEY_W-1:0]   key_q;
  logic               dec_q;
  logic [RC_W-1:0]    rc;
  logic [BLOCK_W-1:0] out_q;

  logic [H-1:0] l_chain [UNROLL+1];
  logic [H-1:0] r_chain [UNROLL+1];

  assign l_chain[0] = l_q;
  assign r_chain[0] = r_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    logic [H-1:0] k;
    // Index is clamped so the idle/finished counter value never produces a negative round index.
    always_comb begin
      int i;
      int idx;
      i = int'(rc) + j;
      if (i >= ROUNDS) i = ROUNDS - 1;
      idx = dec_q ? (ROUNDS - 1 - i) : i;
      k   = H'(subkey(MAX_W'(key_q), idx, KEY_W, H, KEY_ROT));
    end

    feistel_round #(.H(H)) u_round (
      .l  (l_chain[j]),
      .r  (r_chain[j]),
      .k  (k),
      .l_n(l_chain[j+1]),
      .r_n(r_chain[j+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      l_q   <= '0;
      r_q   <= '0;
      key_q <= '0;
      dec_q <= 1'b0;
      rc    <= '0;
      out_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            l_q   <= in_block[BLOCK_W-1:H];
            r_q   <= in_block[H-1:0];
            key_q <= in_key;
            dec_q <= in_decrypt;
            rc    <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Once every round group is applied, one more cycle registers the swapped result.
          if (rc == RC_W'(ROUNDS)) begin
            out_q <= {r_q, l_q};
            state <= ST_DONE;
          end else begin
            l_q <= l_chain[UNROLL];
            r_q <= r_chain[UNROLL];
            rc  <= rc + RC_W'(UNROLL);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
`ifdef FEISTEL_KEY_CLEAR_EN
            key_q <= '0;
            l_q   <= '0;
            r_q   <= '0;
            out_q <= '0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

`ifdef FEISTEL_KEY_CLEAR_EN
  assign out_block = out_valid ? out_q : '0;
`else
  assign out_block = out_q;
`endif

endmodule

// File: tb/tb_feistel_iter_core.sv
// tb/tb_feistel_iter_core.sv - bench for feistel_iter_core: ROUNDS=16/UNROLL=1, UNROLL=4 and ROUNDS=1 instances
module tb_feistel_iter_core;
  import feistel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_decrypt = 1'b0;
  logic [63:0] in_block = '0;
  logic [55:0] in_key = '0;
  logic        out_ready = 1'b1;

  logic        rdy16, val16, busy16;
  logic        rdy4, val4, busy4;
  logic        rdy1, val1, busy1;
  logic [63:0] ob16, ob4, ob1;

  always #5 clk = ~clk;

  feistel_iter_core d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_decrypt(in_decrypt),
    .in_block(in_block), .in_key(in_key), .out_valid(val16), .out_ready(out_ready),
    .out_block(ob16), .busy(busy16)
  );

  feistel_iter_core #(.UNROLL(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_decrypt(in_decrypt),
    .in_block(in_block), .in_key(in_key), .out_valid(val4), .out_ready(out_ready),
    .out_block(ob4), .busy(busy4)
  );

  feistel_iter_core #(.ROUNDS(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_decrypt(in_decrypt),
    .in_block(in_block), .in_key(in_key), .out_valid(val1), .out_ready(out_ready),
    .out_block(ob1), .busy(busy1)
  );

  typedef struct {
    logic        dec;
    logic [63:0] blk;
    logic [55:0] key;
    logic [63:0] exp16;
    logic [63:0] exp1;
  } vec_t;

  vec_t        vecs [7];
  logic [63:0] q16 [$];
  logic [63:0] q4 [$];
  logic [63:0] q1 [$];
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [55:0] ks(input logic [55:0] key, input int idx);
    logic [111:0] t;
    int s;
    s = (idx * 4) % 56;
    t = {key, key} << s;
    return t[111:56];
  endfunction

  function automatic logic [63:0] model(input logic [63:0] blk, input logic [55:0] key,
                                        input logic dec, input int rounds);
    logic [31:0] l, r, k, t, f, nr;
    logic [55:0] kk;
    int idx;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < rounds; i++) begin
      idx = dec ? (rounds - 1 - i) : i;
      kk  = ks(key, idx);
      k   = kk[31:0];
      t   = r ^ k;
      f   = {t[26:0], t[31:27]} + k;
      nr  = l ^ f;
      l   = r;
      r   = nr;
    end
    return {r, l};
  endfunction

  task automatic send(input logic dec, input logic [63:0] blk, input logic [55:0] key);
    int n;
    n = 0;
    while (!(rdy16 && rdy4 && rdy1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      $display("FAIL ready_timeout: got in_ready=%b%b%b expected 111", rdy16, rdy4, rdy1);
    end
    in_valid   = 1'b1;
    in_decrypt = dec;
    in_block   = blk;
    in_key     = key;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect();
    int l16, l4, l1;
    logic [63:0] b16, b4, b1, e;
    l16 = -1; l4 = -1; l1 = -1;
    b16 = '0; b4 = '0; b1 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (val16 && l16 < 0) begin l16 = c; b16 = ob16; end
      if (val4 && l4 < 0) begin l4 = c; b4 = ob4; end
      if (val1 && l1 < 0) begin l1 = c; b1 = ob1; end
    end
    check("latency16", 64'(l16), 64'd17);
    check("latency4", 64'(l4), 64'd5);
    check("latency1", 64'(l1), 64'd2);
    e = q16.pop_front(); check("data16", b16, e);
    e = q4.pop_front();  check("data4", b4, e);
    e = q1.pop_front();  check("data1", b1, e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]  x, c, hold;
    logic [55:0]  key, ksv;
    logic [127:0] sk;
    int           n;

    vecs[0] = '{1'b0, 64'h0000_0000_0000_0001, 56'h0,
                model(64'h0000_0000_0000_0001, 56'h0, 1'b0, 16), 64'h0000_0020_0000_0001};
    for (int p = 0; p < 3; p++) begin
      x   = {$urandom(), $urandom()};
      key = 56'({$urandom(), $urandom()});
      c   = model(x, key, 1'b0, 16);
      vecs[1+2*p] = '{1'b0, x, key, c, model(x, key, 1'b0, 1)};
      vecs[2+2*p] = '{1'b1, c, key, x, model(c, key, 1'b1, 1)};
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready16", 64'(rdy16), 64'd1);
    check("rst_valid16", 64'(val16), 64'd0);
    check("rst_block16", ob16, 64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_ready4", 64'(rdy4), 64'd1);
    check("rst_valid1", 64'(val1), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      sk  = subkey(128'(vecs[1].key), i * 5);
      ksv = ks(vecs[1].key, i * 5);
      check("subkey", 64'(sk), {32'h0, ksv[31:0]});
    end

    for (int v = 0; v < 7; v++) begin
      q16.push_back(vecs[v].exp16);
      q4.push_back(vecs[v].exp16);
      q1.push_back(vecs[v].exp1);
      send(vecs[v].dec, vecs[v].blk, vecs[v].key);
      collect();
    end

    // Backpressure: result held in DONE while a second offer is ignored.
    out_ready = 1'b0;
    hold = vecs[1].exp16;
    send(vecs[1].dec, vecs[1].blk, vecs[1].key);
    n = 0;
    while (!val16 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", 64'(val16), 64'd1);
    in_valid = 1'b1;
    in_block = ~vecs[1].blk;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(val16), 64'd1);
      check("bp_block", ob16, hold);
      check("bp_in_ready", 64'(rdy16), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_busy", 64'(busy16), 64'd0);
    check("post_hs_ready", 64'(rdy16), 64'd1);
    check("post_hs_valid", 64'(val16), 64'd0);
`ifdef FEISTEL_KEY_CLEAR_EN
    check("clear_out_block", ob16, 64'd0);
    check("clear_key_reg", 64'(d16.key_q), 64'd0);
`else
    check("hold_out_block", ob16, hold);
`endif

    // Reset in the middle of RUN aborts the block.
    send(vecs[3].dec, vecs[3].blk, vecs[3].key);
    repeat (7) @(posedge clk);
    #1;
    check("mid_run_busy", 64'(busy16), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 64'(rdy16), 64'd1);
    check("abort_valid", 64'(val16), 64'd0);
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_block", ob16, 64'd0);

    q16.push_back(vecs[4].exp16);
    q4.push_back(vecs[4].exp16);
    q1.push_back(vecs[4].exp1);
    send(vecs[4].dec, vecs[4].blk, vecs[4].key);
    collect();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
